// File: rtl/instr_ram_loadable.sv
// rtl/instr_ram_loadable.sv - loadable synchronous-read instruction RAM for the pipelined MIPS core
// Run-time program load through a word-stream port; one-cycle fetch with stall hold and PC error flag.
module instr_ram_loadable #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  busy,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_pc,
  input  logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  fetch_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

  typedef enum logic {RUN, LOAD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_index;
  logic                  pc_err;
  logic                  write_en;
  logic                  unused_kernel_bit;

  // Bit 31 is the kernel flag; kernel PCs alias onto the same words.
  assign unused_kernel_bit = fetch_pc[31];
  assign fetch_index = fetch_pc[ADDR_WIDTH+1:2];
  assign pc_err      = (|fetch_pc[1:0]) | (|fetch_pc[30:ADDR_WIDTH+2]);

  assign busy       = (state == LOAD);
  assign load_ready = (state == LOAD);
  assign write_en   = (state == LOAD) && load_valid && (remaining != CNT_ZERO);

  // Array kept out of the reset domain so a reset mid-load preserves written words.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      ptr         <= '0;
      remaining   <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      instruction <= '0;
      fetch_err   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        RUN: begin
          if (load_start) begin
            state       <= LOAD;
            ptr         <= load_base;
            remaining   <= load_count;
            fetch_valid <= 1'b0;
          end else if (!fetch_stall) begin
            if (fetch_req) begin
              fetch_valid <= 1'b1;
              fetch_err   <= pc_err;
              instruction <= pc_err ? NOP_WORD : mem[fetch_index];
            end else begin
              fetch_valid <= 1'b0;
              fetch_err   <= 1'b0;
            end
          end
        end
        LOAD: begin
          fetch_valid <= 1'b0;
          if (remaining == CNT_ZERO) begin
            state     <= RUN;
            load_done <= 1'b1;
          end else if (load_valid) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state     <= RUN;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_loadable.sv
// tb/tb_instr_ram_loadable.sv - directed self-checking bench for instr_ram_loadable
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_instr_ram_loadable;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  load_base = '0;
  logic [8:0]  load_count = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready, load_done, busy;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_stall = 1'b0;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_ram_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(32'h00000000)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .busy(busy),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({fetch_valid, fetch_err, load_ready, load_done, busy} !== 5'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: fv=%b err=%b rdy=%b done=%b busy=%b instr=%h required all 0",
               fetch_valid, fetch_err, load_ready, load_done, busy, instruction);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [31:0] words [3];
    int ready_cycles;
    words[0] = 32'h3C0D4000; words[1] = 32'hADA00008; words[2] = 32'h00000000;
    ready_cycles = 0;
    load_start = 1'b1; load_base = 8'd16; load_count = 9'd3;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (load_ready) ready_cycles++;
      checks++;
      if (load_done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL load_word%0d_status: done=%b busy=%b required done=0 busy=1", i, load_done, busy);
      end
      load_valid = 1'b1; load_data = words[i];
      tick();
    end
    load_valid = 1'b0;
    if (load_ready) ready_cycles++;
    checks++;
    if (ready_cycles != 3) begin
      errors++;
      $display("FAIL load_ready_cycles: got %0d required 3", ready_cycles);
    end
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse: done=%b busy=%b required done=1 busy=0", load_done, busy);
    end
    tick();
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL load_done_width: done=%b required 0", load_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] exp [3];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48;
    exp[0] = 32'h3C0D4000; exp[1] = 32'hADA00008; exp[2] = 32'h00000000;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instruction !== exp[i]) begin
        errors++;
        $display("FAIL b2b_fetch%0d: fv=%b err=%b instr=%h required fv=1 err=0 instr=%h",
                 i, fetch_valid, fetch_err, instruction, exp[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_fetch: fv=%b err=%b instr=%h required 0 0 00000000",
               fetch_valid, fetch_err, instruction);
    end
  endtask

  task automatic test_stall();
    fetch_req = 1'b1; fetch_pc = 32'h40;
    tick();
    fetch_stall = 1'b1; fetch_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || instruction !== 32'h3C0D4000) begin
        errors++;
        $display("FAIL stall_hold%0d: fv=%b instr=%h required fv=1 instr=3c0d4000", i, fetch_valid, instruction);
      end
    end
    fetch_stall = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || instruction !== 32'hADA00008) begin
      errors++;
      $display("FAIL stall_release: fv=%b instr=%h required fv=1 instr=ada00008", fetch_valid, instruction);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] pcs [3];
    logic [31:0] exp_instr [3];
    logic        exp_err [3];
    pcs[0] = 32'h42;       exp_err[0] = 1'b1; exp_instr[0] = 32'h0;
    pcs[1] = 32'h400;      exp_err[1] = 1'b1; exp_instr[1] = 32'h0;
    pcs[2] = 32'h80000040; exp_err[2] = 1'b0; exp_instr[2] = 32'h3C0D4000;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== exp_err[i] || instruction !== exp_instr[i]) begin
        errors++;
        $display("FAIL pc_decode_%h: fv=%b err=%b instr=%h required fv=1 err=%b instr=%h",
                 pcs[i], fetch_valid, fetch_err, instruction, exp_err[i], exp_instr[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_wrap_gaps();
    logic [31:0] words [4];
    logic [31:0] pcs [4];
    int w, dones;
    logic busy_drop;
    words[0] = 32'h11110001; words[1] = 32'h22220002; words[2] = 32'h33330003; words[3] = 32'h44440004;
    pcs[0] = 32'h3F8; pcs[1] = 32'h3FC; pcs[2] = 32'h000; pcs[3] = 32'h004;
    w = 0; dones = 0; busy_drop = 1'b0;
    load_start = 1'b1; load_base = 8'd254; load_count = 9'd4;
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (busy !== 1'b1) busy_drop = 1'b1;
      if (load_done === 1'b1) dones++;
      load_valid = (c % 2 == 0);
      load_data = (c % 2 == 0) ? words[w] : 32'hDEADBEEF;
      if (c % 2 == 0) w++;
      tick();
    end
    load_valid = 1'b0;
    if (load_done === 1'b1) dones++;
    tick();
    if (load_done === 1'b1) dones++;
    checks++;
    if (busy_drop || dones != 1) begin
      errors++;
      $display("FAIL wrap_busy_done: busy_drop=%b done_pulses=%0d required busy_drop=0 done_pulses=1", busy_drop, dones);
    end
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = pcs[i];
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || instruction !== words[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: fv=%b err=%b instr=%h required 1 0 %h",
                 i, fetch_valid, fetch_err, instruction, words[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_count_zero();
    load_start = 1'b1; load_base = 8'd16; load_count = 9'd0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'hBAD0BAD0;
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_enter: busy=%b done=%b required busy=1 done=0", busy, load_done);
    end
    tick();
    load_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_exit: busy=%b done=%b required busy=0 done=1", busy, load_done);
    end
    fetch_req = 1'b1; fetch_pc = 32'h40;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (instruction !== 32'h3C0D4000) begin
      errors++;
      $display("FAIL zero_mem_unchanged: instr=%h required 3c0d4000", instruction);
    end
  endtask

  task automatic test_start_vs_fetch();
    fetch_req = 1'b1; fetch_pc = 32'h44;
    tick();
    load_start = 1'b1; load_base = 8'd100; load_count = 9'd1;
    tick();
    load_start = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_fetch: fv=%b busy=%b required fv=0 busy=1", fetch_valid, busy);
    end
    load_valid = 1'b1; load_data = 32'h24080005;
    tick();
    load_valid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL load_ignores_fetch: fv=%b done=%b required fv=0 done=1", fetch_valid, load_done);
    end
    fetch_pc = 32'h190;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b1 || instruction !== 32'h24080005) begin
      errors++;
      $display("FAIL single_word_load: fv=%b instr=%h required fv=1 instr=24080005", fetch_valid, instruction);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    int dones;
    dones = 0;
    load_start = 1'b1; load_base = 8'd40; load_count = 9'd5;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'hAAAA0001;
    tick();
    load_data = 32'hBBBB0002;
    tick();
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({fetch_valid, fetch_err, load_ready, load_done, busy} !== 5'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_load: fv=%b err=%b rdy=%b done=%b busy=%b instr=%h required all 0",
               fetch_valid, fetch_err, load_ready, load_done, busy, instruction);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_no_done: bad_cycles=%0d required 0", dones);
    end
    fetch_req = 1'b1; fetch_pc = 32'hA0;
    tick();
    checks++;
    if (instruction !== 32'hAAAA0001 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL kept_word0: fv=%b instr=%h required fv=1 instr=aaaa0001", fetch_valid, instruction);
    end
    fetch_pc = 32'hA4;
    tick();
    checks++;
    if (instruction !== 32'hBBBB0002 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL kept_word1: fv=%b instr=%h required fv=1 instr=bbbb0002", fetch_valid, instruction);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_errors();
    test_wrap_gaps();
    test_count_zero();
    test_start_vs_fetch();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
